// File: rtl/tile_painter_pkg.sv
// Shared types, frame constants and the border shading helper for tile_painter.
package tile_painter_pkg;

    typedef enum logic [1:0] {
        DRAW_TILE    = 2'b00,
        CLEAR_TILE   = 2'b01,
        CLEAR_SCREEN = 2'b10,
        NOP          = 2'b11
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        PAINT = 1'b1
    } state_t;

    localparam int TILE_W  = 8;
    localparam int FRAME_W = 128;

    // Halve each 4-bit R/G/B channel independently (no carry between channels).
    function automatic logic [11:0] shade(input logic [11:0] color);
        return {1'b0, color[11:9], 1'b0, color[7:5], 1'b0, color[3:1]};
    endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// Row/col pixel counter pair; wraps at the tile edge or, in full mode, the frame edge.
module tile_pixel_counter #(
    parameter int CW = 7,
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    input  logic          full,
    output logic [CW-1:0] row_nxt,
    output logic [CW-1:0] col_nxt,
    output logic          last
);
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TILE_MAX = {{(CW-TW){1'b0}}, {TW{1'b1}}};

    logic [CW-1:0] row, col, lim;
    logic          col_end, row_end;

    always_comb begin
        lim     = full ? {CW{1'b1}} : TILE_MAX;
        col_end = (col == lim);
        row_end = (row == lim);
        last    = col_end && row_end;
        col_nxt = col_end ? '0 : col + ONE;
        row_nxt = col_end ? (row_end ? '0 : row + ONE) : row;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

endmodule

// File: rtl/tile_painter.sv
// Tile drawing engine: turns one command into a burst of single-pixel RAM writes.
module tile_painter
    import tile_painter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 14,
    parameter int                    TILE_BITS  = 3,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR   = 12'h000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [ADDR_WIDTH/2-TILE_BITS-1:0] cmd_tx,
    input  logic [ADDR_WIDTH/2-TILE_BITS-1:0] cmd_ty,
    input  logic [DATA_WIDTH-1:0]             cmd_color,
    output logic                              we,
    output logic [ADDR_WIDTH-1:0]             addr_w,
    output logic [DATA_WIDTH-1:0]             din,
    output logic                              busy,
    output logic                              done
);
    localparam int CW = ADDR_WIDTH / 2;
    localparam int TW = TILE_BITS;
    localparam int XW = CW - TW;
    localparam logic [TW-1:0] TMAX = {TW{1'b1}};

    state_t                state, state_n;
    op_t                   op_q, op_s;
    logic [XW-1:0]         tx_q, ty_q, tx_s, ty_s;
    logic [DATA_WIDTH-1:0] color_q, color_s, din_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [CW-1:0]         row_nxt, col_nxt, pix_row, pix_col;
    logic                  idle, border, cnt_last, cnt_clear, cnt_step, latch, we_n, done_n;

    tile_pixel_counter #(.CW(CW), .TW(TW)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .step    (cnt_step),
        .full    (op_q == CLEAR_SCREEN),
        .row_nxt (row_nxt),
        .col_nxt (col_nxt),
        .last    (cnt_last)
    );

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        we_n      = 1'b0;
        done_n    = 1'b0;
        latch     = 1'b0;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                latch = 1'b1;
                if (op_t'(cmd_op) == NOP) begin
                    done_n = 1'b1;
                end else begin
                    state_n   = PAINT;
                    we_n      = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            PAINT: if (cnt_last) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                we_n     = 1'b1;
                cnt_step = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // The output registers are loaded one pixel ahead: on acceptance pixel (0,0)
    // comes straight from the command inputs, afterwards from the counter's next value.
    always_comb begin
        idle    = (state == IDLE);
        op_s    = idle ? op_t'(cmd_op) : op_q;
        tx_s    = idle ? cmd_tx : tx_q;
        ty_s    = idle ? cmd_ty : ty_q;
        color_s = idle ? cmd_color : color_q;
        pix_row = idle ? '0 : row_nxt;
        pix_col = idle ? '0 : col_nxt;
        border  = (pix_row[TW-1:0] == '0) || (pix_row[TW-1:0] == TMAX) ||
                  (pix_col[TW-1:0] == '0) || (pix_col[TW-1:0] == TMAX);
        if (op_s == CLEAR_SCREEN) addr_n = {pix_row, pix_col};
        else                      addr_n = {ty_s, pix_row[TW-1:0], tx_s, pix_col[TW-1:0]};
        if (op_s == DRAW_TILE) din_n = border ? shade(color_s) : color_s;
        else                   din_n = BG_COLOR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= NOP;
            tx_q    <= '0;
            ty_q    <= '0;
            color_q <= '0;
            we      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr_w  <= '0;
            din     <= '0;
        end else begin
            we   <= we_n;
            busy <= we_n;
            done <= done_n;
            if (we_n) begin
                addr_w <= addr_n;
                din    <= din_n;
            end
            if (latch) begin
                op_q    <= op_t'(cmd_op);
                tx_q    <= cmd_tx;
                ty_q    <= cmd_ty;
                color_q <= cmd_color;
            end
        end
    end

endmodule

// File: tb/tb_tile_painter.sv
// Directed bench for tile_painter: drives on negedge, samples on negedge before driving.
module tb_tile_painter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_tx = '0, cmd_ty = '0;
    logic [11:0] cmd_color = '0;
    logic        cmd_ready, we, busy, done;
    logic [13:0] addr_w;
    logic [11:0] din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_painter dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_tx    (cmd_tx),
        .cmd_ty    (cmd_ty),
        .cmd_color (cmd_color),
        .we        (we),
        .addr_w    (addr_w),
        .din       (din),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tile write i lands at ty*1024 + row*128 + tx*8 + col; border pixels carry edge_c.
    task automatic tile_writes(input string tag, input int tx, input int ty,
                               input logic [11:0] fill, input logic [11:0] edge_c,
                               input int first, input int last);
        for (int i = first; i < last; i++) begin
            int r, c;
            r = i / 8;
            c = i % 8;
            check({tag, "_we"}, we, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_done"}, done, 0);
            check({tag, "_ready"}, cmd_ready, 0);
            check({tag, "_addr"}, addr_w, ty*1024 + r*128 + tx*8 + c);
            check({tag, "_din"}, din, (r == 0 || r == 7 || c == 0 || c == 7) ? edge_c : fill);
            @(negedge clk);
        end
    endtask

    task automatic done_cycle(input string tag);
        check({tag, "_end_we"}, we, 0);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_done"}, done, 1);
        check({tag, "_end_ready"}, cmd_ready, 1);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr_w, 0);
        check("rst_din", din, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);

        // NOP: done next cycle, no write, ready stays high
        cmd_valid = 1'b1; cmd_op = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("nop_done", done, 1);
        check("nop_we", we, 0);
        check("nop_ready", cmd_ready, 1);
        @(negedge clk);
        check("nop_done_clr", done, 0);
        check("nop_we2", we, 0);

        // DRAW_TILE (2,3) F84, with an intruding command while busy
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tx = 4'd2; cmd_ty = 4'd3; cmd_color = 12'hF84;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("draw_first_addr", addr_w, 14'd3088);
        check("draw_first_din", din, 12'h742);
        tile_writes("draw", 2, 3, 12'hF84, 12'h742, 0, 10);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_tx = 4'd9; cmd_ty = 4'd9; cmd_color = 12'hFFF;
        tile_writes("busyvalid", 2, 3, 12'hF84, 12'h742, 10, 20);
        cmd_valid = 1'b0;
        tile_writes("draw", 2, 3, 12'hF84, 12'h742, 20, 27);
        check("draw_px33_addr", addr_w, 14'd3475);
        check("draw_px33_din", din, 12'hF84);
        tile_writes("draw", 2, 3, 12'hF84, 12'h742, 27, 63);
        check("draw_px77_addr", addr_w, 14'd3991);
        check("draw_px77_din", din, 12'h742);
        tile_writes("draw", 2, 3, 12'hF84, 12'h742, 63, 64);
        done_cycle("draw");
        @(negedge clk);
        check("draw_done_clr", done, 0);

        // back-to-back: valid held, second command taken in the done cycle
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tx = 4'd0; cmd_ty = 4'd0; cmd_color = 12'h0AC;
        @(negedge clk);
        cmd_op = 2'b01; cmd_tx = 4'd15; cmd_ty = 4'd15; cmd_color = 12'h123;
        tile_writes("b2b_a", 0, 0, 12'h0AC, 12'h056, 0, 64);
        done_cycle("b2b_a");
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_b_first_addr", addr_w, 14'd15480);
        tile_writes("b2b_b", 15, 15, 12'h000, 12'h000, 0, 63);
        check("b2b_last_addr", addr_w, 14'd16383);
        tile_writes("b2b_b", 15, 15, 12'h000, 12'h000, 63, 64);
        done_cycle("b2b_b");
        @(negedge clk);

        // CLEAR_SCREEN: every address in order, background data
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_tx = 4'd5; cmd_ty = 4'd6; cmd_color = 12'hABC;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            check("cs_we", we, 1);
            check("cs_addr", addr_w, i);
            check("cs_din", din, 12'h000);
            @(negedge clk);
        end
        done_cycle("cs");
        @(negedge clk);

        // reset asserted during the 20th write of a DRAW_TILE
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tx = 4'd1; cmd_ty = 4'd1; cmd_color = 12'h555;
        @(negedge clk);
        cmd_valid = 1'b0;
        tile_writes("pre_rst", 1, 1, 12'h555, 12'h222, 0, 19);
        check("rst20_we", we, 1);
        check("rst20_addr", addr_w, 14'd1291);
        reset = 1'b1;
        @(negedge clk);
        check("abort_we", we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", addr_w, 0);
        check("abort_din", din, 0);
        check("abort_ready", cmd_ready, 1);
        @(negedge clk);
        check("abort_done2", done, 0);
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_tx = 4'd4; cmd_ty = 4'd0; cmd_color = 12'hFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        tile_writes("post_rst", 4, 0, 12'h000, 12'h000, 0, 64);
        done_cycle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
